// File: rtl/scr1_tb_test_ctrl.sv
// Test-run sequencer for the SCR1 simulation environments: core reset and image load,
// exit-PC monitoring across harts, a0-based grading, cycle timeout and regression counters.
module scr1_tb_test_ctrl #(
    parameter int unsigned     NUM_HARTS  = 1,
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] EXIT_ADDR  = 'h000000F8,
    parameter int unsigned     RST_CYCLES = 4,
    parameter int unsigned     CNT_W      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [CNT_W-1:0]          timeout_limit_i,
    input  logic [NUM_HARTS-1:0]      hart_pc_vld_i,
    input  logic [NUM_HARTS*XLEN-1:0] hart_pc_i,
    input  logic [NUM_HARTS*XLEN-1:0] hart_a0_i,
    output logic                      core_rst_n_o,
    output logic                      mem_init_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_flag_o,
    output logic [NUM_HARTS-1:0]      hart_exit_mask_o,
    output logic [CNT_W-1:0]          cycle_cnt_o,
    output logic [15:0]               tests_total_o,
    output logic [15:0]               tests_passed_o
);

    localparam int unsigned  RcW     = $clog2(RST_CYCLES + 1);
    localparam logic [RcW-1:0] RstLoad = RcW'(RST_CYCLES);

    typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [RcW-1:0]       rcnt_q, rcnt_d;
    logic                 core_rst_n_q, core_rst_n_d;
    logic                 mem_init_q, mem_init_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_HARTS-1:0] mask_q, mask_d;
    logic [NUM_HARTS-1:0] hpass_q, hpass_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          total_q, total_d;
    logic [15:0]          passed_q, passed_d;
    logic                 run_end;

    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        core_rst_n_d = core_rst_n_q;
        mem_init_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        mask_d       = mask_q;
        hpass_d      = hpass_q;
        cnt_d        = cnt_q;
        total_d      = total_q;
        passed_d     = passed_q;
        run_end      = 1'b0;

        unique case (state_q)
            StIdle: begin
                core_rst_n_d = 1'b0;
                busy_d       = 1'b0;
                if (start_i) begin
                    state_d    = StReset;
                    rcnt_d     = RstLoad;
                    mem_init_d = 1'b1;
                    busy_d     = 1'b1;
                    mask_d     = '0;
                    hpass_d    = '0;
                    cnt_d      = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            StReset: begin
                if (rcnt_q == '0) begin
                    state_d      = StRun;
                    core_rst_n_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q - RcW'(1);
                end
            end
            StRun: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Only the first exit of each hart is graded; later matches are ignored.
                for (int unsigned i = 0; i < NUM_HARTS; i++) begin
                    if (!mask_q[i] && hart_pc_vld_i[i] && hart_pc_i[i*XLEN +: XLEN] == EXIT_ADDR) begin
                        mask_d[i]  = 1'b1;
                        hpass_d[i] = (hart_a0_i[i*XLEN +: XLEN] == '0);
                    end
                end
                if (&mask_d) begin
                    run_end = 1'b1;
                    pass_d  = &hpass_d;
                end else if (timeout_limit_i != '0 && cnt_q + CNT_W'(1) == timeout_limit_i) begin
                    run_end   = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
                if (run_end) begin
                    state_d      = StDone;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    core_rst_n_d = 1'b0;
                    if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
                    if (pass_d && passed_q != 16'hFFFF) passed_d = passed_q + 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            rcnt_q       <= '0;
            core_rst_n_q <= 1'b0;
            mem_init_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            mask_q       <= '0;
            hpass_q      <= '0;
            cnt_q        <= '0;
            total_q      <= '0;
            passed_q     <= '0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            core_rst_n_q <= core_rst_n_d;
            mem_init_q   <= mem_init_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            mask_q       <= mask_d;
            hpass_q      <= hpass_d;
            cnt_q        <= cnt_d;
            total_q      <= total_d;
            passed_q     <= passed_d;
        end
    end

    assign core_rst_n_o     = core_rst_n_q;
    assign mem_init_o       = mem_init_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_flag_o   = timeout_q;
    assign hart_exit_mask_o = mask_q;
    assign cycle_cnt_o      = cnt_q;
    assign tests_total_o    = total_q;
    assign tests_passed_o   = passed_q;

endmodule
